// File: rtl/gcd_dispatch_if.sv
// Handshake bundle between the operand producer, the dispatcher, the GCD
// engine and the result consumer. The dispatcher uses the slave view; the
// surrounding environment (producer, engine, consumer) uses the master view.
interface gcd_dispatch_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  IN_A;
    logic [7:0]  IN_B;
    logic        ENG_START;
    logic [7:0]  ENG_A;
    logic [7:0]  ENG_B;
    logic        ENG_DONE;
    logic        ENG_ERROR;
    logic [7:0]  ENG_Y;
    logic [15:0] ENG_LCM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  OUT_Y;
    logic [15:0] OUT_LCM;
    logic [1:0]  OUT_ERR;
    logic [3:0]  OUT_TAG;

    modport slave (
        input  IN_VALID, IN_A, IN_B,
        input  ENG_DONE, ENG_ERROR, ENG_Y, ENG_LCM,
        input  OUT_READY,
        output IN_READY, ENG_START, ENG_A, ENG_B,
        output OUT_VALID, OUT_Y, OUT_LCM, OUT_ERR, OUT_TAG
    );

    modport master (
        output IN_VALID, IN_A, IN_B,
        output ENG_DONE, ENG_ERROR, ENG_Y, ENG_LCM,
        output OUT_READY,
        input  IN_READY, ENG_START, ENG_A, ENG_B,
        input  OUT_VALID, OUT_Y, OUT_LCM, OUT_ERR, OUT_TAG
    );
endinterface

// File: rtl/gcd_dispatch.sv
// GCD job dispatcher: queues operand pairs with a job tag, issues them one at
// a time to an external GCD engine, guards each job with a WAIT timeout and
// holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | no job in flight; pops the FIFO head when one is queued
// ISSUE | one-cycle ENG_START pulse, timeout counter cleared
// WAIT  | waiting for ENG_DONE or the timeout
// HOLD  | OUT_VALID asserted until OUT_READY
module gcd_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input logic           CLK,
    input logic           RST_N,
    gcd_dispatch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [7:0]  TC_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t         state, state_nx;
    logic [19:0]    fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [3:0]     job_cnt;
    logic [7:0]     tcnt;
    logic [7:0]     eng_a, eng_b, out_y;
    logic [15:0]    out_lcm;
    logic [1:0]     out_err;
    logic [3:0]     out_tag;
    logic           push, pop, timeout_hit;
    logic [19:0]    head;

    assign bus.IN_READY  = (count < FULL_CNT);
    assign push          = bus.IN_VALID && bus.IN_READY;
    assign head          = fifo_mem[rd_ptr];
    assign timeout_hit   = (tcnt == TC_LAST);

    assign bus.ENG_START = (state == ISSUE);
    assign bus.ENG_A     = eng_a;
    assign bus.ENG_B     = eng_b;
    assign bus.OUT_VALID = (state == HOLD);
    assign bus.OUT_Y     = out_y;
    assign bus.OUT_LCM   = out_lcm;
    assign bus.OUT_ERR   = out_err;
    assign bus.OUT_TAG   = out_tag;

    // FIFO storage: {tag, a, b} per entry; contents need no reset
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= {job_cnt, bus.IN_A, bus.IN_B};
    end

    // FIFO pointers, occupancy and job tag counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            job_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                job_cnt <= job_cnt + 4'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next state and FIFO pop; ENG_DONE wins over a coincident timeout
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.ENG_DONE || timeout_hit) state_nx = HOLD;
            HOLD:    if (bus.OUT_READY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Job operands, timeout counter and result capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            eng_a   <= '0;
            eng_b   <= '0;
            out_tag <= '0;
            out_y   <= '0;
            out_lcm <= '0;
            out_err <= 2'b00;
            tcnt    <= '0;
        end else begin
            if (pop) begin
                {out_tag, eng_a, eng_b} <= head;
            end
            if (state == ISSUE) tcnt <= '0;
            if (state == WAIT) begin
                if (bus.ENG_DONE) begin
                    out_y   <= bus.ENG_Y;
                    out_lcm <= bus.ENG_LCM;
                    out_err <= bus.ENG_ERROR ? 2'b01 : 2'b00;
                end else if (timeout_hit) begin
                    out_y   <= '0;
                    out_lcm <= '0;
                    out_err <= 2'b10;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a behavioural GCD engine, a result
// monitor and an expected-result queue filled as operands are accepted.
module tb_gcd_dispatch;
    logic CLK = 1'b0;
    logic RST_N;
    gcd_dispatch_if bus ();

    gcd_dispatch #(.DEPTH(4), .TIMEOUT(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // expected / observed entries: {tag, y, lcm, err}
    logic [29:0] exp_q[$];
    logic [29:0] got_q[$];
    logic [3:0]  exp_tag = 4'd0;

    int          eng_mode  = 0;   // 0 respond, 1 never respond
    int          eng_delay = 5;
    int          start_cnt = 0;
    logic [7:0]  last_a, last_b;
    logic        eng_unstable = 1'b0;

    function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    function automatic logic [15:0] lcm_f(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] g;
        g = gcd_f(a, b);
        if (g == 0) return 16'd0;
        return (16'(a) * 16'(b)) / 16'(g);
    endfunction

    // behavioural engine: answers each ENG_START after eng_delay cycles
    initial begin
        logic [7:0] ea, eb;
        bus.ENG_DONE = 1'b0; bus.ENG_ERROR = 1'b0;
        bus.ENG_Y = 8'd0; bus.ENG_LCM = 16'd0;
        forever begin
            @(posedge CLK); #1;
            if (bus.ENG_START === 1'b1) begin
                start_cnt++;
                ea = bus.ENG_A; eb = bus.ENG_B;
                last_a = ea; last_b = eb;
                if (eng_mode == 0) begin
                    repeat (eng_delay) begin @(posedge CLK); #1; end
                    if (bus.ENG_A !== ea || bus.ENG_B !== eb) eng_unstable = 1'b1;
                    bus.ENG_DONE  = 1'b1;
                    bus.ENG_Y     = gcd_f(ea, eb);
                    bus.ENG_LCM   = lcm_f(ea, eb);
                    bus.ENG_ERROR = (ea == 0 || eb == 0);
                    @(posedge CLK); #1;
                    bus.ENG_DONE  = 1'b0;
                    bus.ENG_ERROR = 1'b0;
                    bus.ENG_Y     = 8'hA5;
                    bus.ENG_LCM   = 16'h5A5A;
                end
            end
        end
    end

    // result monitor: records every accepted result
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1)
            got_q.push_back({bus.OUT_TAG, bus.OUT_Y, bus.OUT_LCM, bus.OUT_ERR});
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] err,
                        output int waited);
        logic [7:0]  y;
        logic [15:0] l;
        waited = 0;
        bus.IN_VALID = 1'b1; bus.IN_A = a; bus.IN_B = b;
        while (bus.IN_READY !== 1'b1 && waited < 200) begin
            tick(); waited++;
        end
        if (waited >= 200) check("push_accept", {63'd0, bus.IN_READY}, 64'd1);
        y = (err == 2'b10) ? 8'd0  : gcd_f(a, b);
        l = (err == 2'b10) ? 16'd0 : lcm_f(a, b);
        exp_q.push_back({exp_tag, y, l, err});
        exp_tag = exp_tag + 4'd1;
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        logic [29:0] g, e;
        k = 0;
        while (got_q.size() < n && k < 400) begin tick(); k++; end
        check("result_count", 64'(got_q.size()), 64'(n));
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) check("unexpected_result", {34'd0, g}, 64'd0);
            else begin
                e = exp_q.pop_front();
                check("result_tag_y_lcm_err", {34'd0, g}, {34'd0, e});
            end
        end
    endtask

    initial begin
        int w, t0, t1, k, sc;
        logic        stable;
        logic [29:0] snap;
        logic [7:0]  pa [6];
        logic [7:0]  pb [6];
        pa = '{8'd8, 8'd15, 8'd7, 8'd100, 8'd48, 8'd255};
        pb = '{8'd12, 8'd25, 8'd13, 8'd75, 8'd36, 8'd17};

        RST_N = 1'b0;
        bus.IN_VALID = 1'b0; bus.IN_A = 8'd0; bus.IN_B = 8'd0;
        bus.OUT_READY = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", {63'd0, bus.IN_READY}, 64'd1);
        check("rst_eng", {47'd0, bus.ENG_START, bus.ENG_A, bus.ENG_B}, 64'd0);
        check("rst_out", {33'd0, bus.OUT_VALID, bus.OUT_TAG, bus.OUT_Y, bus.OUT_LCM, bus.OUT_ERR}, 64'd0);
        RST_N = 1'b1;
        tick();

        // basic job (12,18) -> 6, 36, tag 0
        push(8'd12, 8'd18, 2'b00, w);
        wait_results(1);
        check("start_pulses", 64'(start_cnt), 64'd1);
        check("issued_ab", {48'd0, last_a, last_b}, {48'd0, 8'd12, 8'd18});

        // zero operand -> engine error reported with tag 1
        push(8'd0, 8'd7, 2'b01, w);
        wait_results(1);

        // timeout: engine silent, TIMEOUT=8
        eng_mode = 1;
        push(8'd9, 8'd3, 2'b10, w);
        k = 0;
        while (bus.ENG_START !== 1'b1 && k < 50) begin tick(); k++; end
        t0 = cyc;
        k = 0;
        while (bus.OUT_VALID !== 1'b1 && k < 50) begin tick(); k++; end
        t1 = cyc;
        check("timeout_latency", 64'(t1 - t0), 64'd9);
        eng_mode = 0;
        wait_results(1);
        push(8'd21, 8'd14, 2'b00, w);
        wait_results(1);

        // back-to-back pushes into a busy engine fill the FIFO
        eng_delay = 6;
        for (int i = 0; i < 5; i++) push(pa[i], pb[i], 2'b00, w);
        check("full_in_ready", {63'd0, bus.IN_READY}, 64'd0);
        push(pa[5], pb[5], 2'b00, w);
        check("stalled_push_waited", {63'd0, (w > 0)}, 64'd1);
        wait_results(6);

        // consumer back-pressure in HOLD
        eng_delay = 5;
        bus.OUT_READY = 1'b0;
        push(8'd30, 8'd45, 2'b00, w);
        push(8'd16, 8'd24, 2'b00, w);
        k = 0;
        while (bus.OUT_VALID !== 1'b1 && k < 50) begin tick(); k++; end
        snap = {bus.OUT_TAG, bus.OUT_Y, bus.OUT_LCM, bus.OUT_ERR};
        sc = start_cnt;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (bus.OUT_VALID !== 1'b1 ||
                {bus.OUT_TAG, bus.OUT_Y, bus.OUT_LCM, bus.OUT_ERR} !== snap) stable = 1'b0;
        end
        check("hold_stable", {63'd0, stable}, 64'd1);
        check("hold_no_start", 64'(start_cnt), 64'(sc));
        bus.OUT_READY = 1'b1;
        k = 0;
        while (bus.ENG_START !== 1'b1 && k < 2) begin tick(); k++; end
        check("issue_after_release", {63'd0, bus.ENG_START}, 64'd1);
        wait_results(2);

        // reset during WAIT with two jobs queued
        eng_mode = 1;
        push(8'd10, 8'd4, 2'b00, w);
        push(8'd6, 8'd9, 2'b00, w);
        push(8'd5, 8'd5, 2'b00, w);
        repeat (2) tick();
        RST_N = 1'b0;
        #1;
        check("midrst_eng", {47'd0, bus.ENG_START, bus.ENG_A, bus.ENG_B}, 64'd0);
        check("midrst_out", {33'd0, bus.OUT_VALID, bus.OUT_TAG, bus.OUT_Y, bus.OUT_LCM, bus.OUT_ERR}, 64'd0);
        check("midrst_in_ready", {63'd0, bus.IN_READY}, 64'd1);
        exp_q.delete();
        exp_tag = 4'd0;
        repeat (3) tick();
        RST_N = 1'b1;
        eng_mode = 0;
        sc = start_cnt;
        repeat (20) tick();
        check("post_rst_no_out", 64'(got_q.size()), 64'd0);
        check("post_rst_no_start", 64'(start_cnt), 64'(sc));
        push(8'd18, 8'd12, 2'b00, w);
        wait_results(1);

        check("eng_operands_stable", {63'd0, eng_unstable}, 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
